// File: rtl/step_phase_decoder.sv
// Closed-loop monitor for a 4-phase stepper drive: filters the phase bus and
// reconstructs steps, direction, position within a revolution and sequence faults.
module step_phase_decoder #(
  parameter int unsigned STABLE_CYC    = 4,
  parameter int unsigned STEPS_PER_REV = 200,
  parameter int unsigned POS_W         = 8,
  parameter int unsigned STALL_CYC     = 1000
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             EN,
  input  logic [3:0]       M_IN,
  input  logic             clr_fault,
  output logic             step_pulse,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             fault,
  output logic [3:0]       err_cnt
);

  typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

  localparam int unsigned     StallW     = $clog2(STALL_CYC + 1);
  localparam logic [3:0]      StableMax  = 4'(STABLE_CYC);
  localparam logic [POS_W-1:0] PosMax    = POS_W'(STEPS_PER_REV - 1);
  localparam logic [StallW-1:0] StallLast = StallW'(STALL_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        sync_q, m_s_q, acc_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        last_idx_q, last_idx_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              moving_q, moving_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic [3:0]        err_q, err_d;

  logic       accept;
  logic       ph_valid, ph_off;
  logic [1:0] ph_idx, idx_fwd, idx_rev;

  // Filter counter restarts whenever the synchronised pattern is about to change.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_q != m_s_q) begin
      cnt_d = 4'd0;
    end else if (cnt_q != StableMax) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  assign accept = (cnt_q == StableMax) && (m_s_q != acc_q);

  always_comb begin
    ph_valid = 1'b1;
    ph_off   = 1'b0;
    ph_idx   = 2'd0;
    unique case (m_s_q)
      4'b1000: ph_idx = 2'd0;
      4'b0100: ph_idx = 2'd1;
      4'b0010: ph_idx = 2'd2;
      4'b0001: ph_idx = 2'd3;
      4'b0000: begin
        ph_valid = 1'b0;
        ph_off   = 1'b1;
      end
      default: ph_valid = 1'b0;
    endcase
  end

  assign idx_fwd = last_idx_q + 2'd1;
  assign idx_rev = last_idx_q - 2'd1;

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    moving_d   = moving_q;
    stall_d    = stall_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept && EN && ph_valid) begin
          state_d    = StTrack;
          last_idx_d = ph_idx;
        end
      end
      StTrack: begin
        if (moving_q) begin
          if (stall_q == StallLast) begin
            moving_d = 1'b0;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
        if (!EN) begin
          state_d  = StIdle;
          moving_d = 1'b0;
        end else if (accept) begin
          if (ph_off) begin
            state_d  = StIdle;
            moving_d = 1'b0;
          end else if (ph_valid && (ph_idx == idx_fwd)) begin
            pos_d      = (pos_q == PosMax) ? '0 : pos_q + 1'b1;
            dir_d      = 1'b1;
            step_d     = 1'b1;
            moving_d   = 1'b1;
            stall_d    = '0;
            last_idx_d = ph_idx;
          end else if (ph_valid && (ph_idx == idx_rev)) begin
            pos_d      = (pos_q == '0) ? PosMax : pos_q - 1'b1;
            dir_d      = 1'b0;
            step_d     = 1'b1;
            moving_d   = 1'b1;
            stall_d    = '0;
            last_idx_d = ph_idx;
          end else begin
            // Skipped phase or illegal pattern.
            state_d  = StFault;
            moving_d = 1'b0;
            err_d    = (err_q == 4'hF) ? err_q : err_q + 4'd1;
          end
        end
      end
      StFault: begin
        if (clr_fault) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= StIdle;
      sync_q     <= 4'd0;
      m_s_q      <= 4'd0;
      acc_q      <= 4'd0;
      cnt_q      <= 4'd0;
      last_idx_q <= 2'd0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      moving_q   <= 1'b0;
      stall_q    <= '0;
      err_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      sync_q     <= M_IN;
      m_s_q      <= sync_q;
      cnt_q      <= cnt_d;
      if (accept) begin
        acc_q <= m_s_q;
      end
      last_idx_q <= last_idx_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      moving_q   <= moving_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  assign step_pulse = step_q;
  assign dir        = dir_q;
  assign pos        = pos_q;
  assign moving     = moving_q;
  assign fault      = (state_q == StFault);
  assign err_cnt    = err_q;

endmodule
